// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both the SPI master and the SPI responder.
// Bus mode constants and the responder FSM state encoding.
package spi_pkg;

  localparam int SPI_CPOL      = 1;
  localparam int SPI_CPHA      = 1;
  localparam int SPI_WORD_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } spi_resp_state_t;

endpackage

// File: rtl/spi_responder_if.sv
// Four-wire SPI pins plus the local TX/RX handshake of the responder.
// SPI_MISO_OE exists only when SPI_RESPONDER_MISO_OE_EN is defined.
interface spi_responder_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  SPI_CLK;
  logic                  SPI_MOSI;
  logic                  SPI_EN;
  logic                  SPI_MISO;
`ifdef SPI_RESPONDER_MISO_OE_EN
  logic                  SPI_MISO_OE;
`endif
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  tx_underrun;
  logic                  frame_err;

  modport slave (
`ifdef SPI_RESPONDER_MISO_OE_EN
    output SPI_MISO_OE,
`endif
    input  SPI_CLK, SPI_MOSI, SPI_EN, tx_data, tx_valid,
    output SPI_MISO, tx_ready, rx_data, rx_valid, tx_underrun, frame_err
  );

  modport master (
`ifdef SPI_RESPONDER_MISO_OE_EN
    input  SPI_MISO_OE,
`endif
    output SPI_CLK, SPI_MOSI, SPI_EN, tx_data, tx_valid,
    input  SPI_MISO, tx_ready, rx_data, rx_valid, tx_underrun, frame_err
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with an extra history flop for rise/fall detection.
// Resets to RESET_VAL so an idle bus produces no spurious edge after reset.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit RESET_VAL   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // NOTE: non-blocking assignments make every stage take the previous stage's old value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_responder.sv
// SPI responder (CPOL=1, CPHA=1, MSB first) oversampled in the clk domain.
// Optional SPI_MISO_OE output is enabled by defining SPI_RESPONDER_MISO_OE_EN.
module spi_responder
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = SPI_WORD_BITS,
  parameter int SYNC_STAGES = 2
) (
  input logic           clk,
  input logic           rst,
  spi_responder_if.slave bus
);

  localparam int                CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_WIDTH);

  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic en_rise, en_fall, en_level_unused;
  logic mosi, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'(SPI_CPOL))) u_sclk_sync (
    .clk(clk), .rst(rst), .d(bus.SPI_CLK),
    .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_en_sync (
    .clk(clk), .rst(rst), .d(bus.SPI_EN),
    .level(en_level_unused), .rise(en_rise), .fall(en_fall)
  );

  // Same depth as SPI_CLK so the sampled data bit lines up with the detected edge.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst(rst), .d(bus.SPI_MOSI),
    .level(mosi), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  spi_resp_state_t       state;
  logic [DATA_WIDTH-1:0] hold_q, tx_shift, rx_shift, rx_data_q;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  hold_full, first_edge;
  logic                  rx_valid_q, underrun_q, frame_err_q, miso_q;
  logic                  tx_capture, to_idle;

  assign tx_capture = bus.tx_valid && !hold_full;
  assign to_idle    = (state != IDLE) && en_rise;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      hold_q      <= '0;
      hold_full   <= 1'b0;
      tx_shift    <= '0;
      rx_shift    <= '0;
      rx_data_q   <= '0;
      bit_cnt     <= '0;
      first_edge  <= 1'b0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
      miso_q      <= 1'b1;
    end else begin
      // NOTE: pulse outputs default low every cycle so no path can leave one stuck high.
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;

      if (tx_capture) begin
        hold_q    <= bus.tx_data;
        hold_full <= 1'b1;
      end

      if (to_idle) begin
        state   <= IDLE;
        miso_q  <= 1'b1;
        bit_cnt <= '0;
        if (state == SHIFT) begin
          if (bit_cnt == FULL_CNT) begin
            rx_data_q  <= rx_shift;
            rx_valid_q <= 1'b1;
          end else if (sclk_rise && bit_cnt == LAST_BIT) begin
            rx_data_q  <= {rx_shift[DATA_WIDTH-2:0], mosi};
            rx_valid_q <= 1'b1;
          end else if (bit_cnt != '0) begin
            frame_err_q <= 1'b1;
          end
        end
      end else begin
        case (state)
          IDLE: begin
            miso_q <= 1'b1;
            if (en_fall) state <= LOAD;
          end
          LOAD: begin
            // Capture and consume never coincide: capture needs an empty holding register.
            tx_shift   <= hold_full ? hold_q : '0;
            miso_q     <= hold_full & hold_q[DATA_WIDTH-1];
            if (hold_full) hold_full  <= 1'b0;
            else           underrun_q <= 1'b1;
            bit_cnt    <= '0;
            first_edge <= 1'(SPI_CPHA);
            state      <= SHIFT;
          end
          SHIFT: begin
            if (bit_cnt == FULL_CNT) begin
              rx_data_q  <= rx_shift;
              rx_valid_q <= 1'b1;
              state      <= LOAD;
            end else begin
              if (sclk_fall) begin
                if (first_edge) begin
                  first_edge <= 1'b0;
                end else begin
                  tx_shift <= tx_shift << 1;
                  miso_q   <= tx_shift[DATA_WIDTH-2];
                end
              end
              if (sclk_rise) begin
                rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi};
                bit_cnt  <= bit_cnt + CNT_W'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef SPI_RESPONDER_MISO_OE_EN
  logic oe_q;

  // Tracks the next FSM state so the enable is high exactly in LOAD and SHIFT.
  always_ff @(posedge clk) begin
    if (!rst)                oe_q <= 1'b0;
    else if (state == IDLE)  oe_q <= en_fall;
    else                     oe_q <= !to_idle;
  end

  assign bus.SPI_MISO_OE = oe_q;
`endif

  assign bus.SPI_MISO    = miso_q;
  assign bus.tx_ready    = ~hold_full;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_underrun = underrun_q;
  assign bus.frame_err   = frame_err_q;

endmodule

// File: doc/spi_responder.md
Name: spi_responder

Overview:
- SPI slave (responder) that pairs with the team's SPI master on the same four-wire bus.
- Bus mode is fixed: CPOL=1, CPHA=1, MSB first, 8-bit words. SPI_EN is an active-low select, high when the bus is idle.
- All bus inputs are oversampled in the local clk domain. A one-entry TX holding buffer is exposed over a valid/ready handshake; each received word is presented as a one-cycle pulse.

Parameters:
- DATA_WIDTH, 8, bits per word.
- SYNC_STAGES, 2, synchronizer flops on SPI_CLK, SPI_MOSI and SPI_EN (minimum 2).

Ports:
- clk  in  1  system clock; must run at least 8x the SPI_CLK frequency.
- rst  in  1  reset; synchronous, active-low.
- SPI_CLK  in  1  bus clock; idles high.
- SPI_MOSI  in  1  master-to-slave data.
- SPI_EN  in  1  select; low means selected.
- SPI_MISO  out  1  slave-to-master data.
- tx_data  in  DATA_WIDTH  next word to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  holding register is empty.
- rx_data  out  DATA_WIDTH  last received word.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- tx_underrun  out  1  one-cycle pulse when a word starts with no TX data available.
- frame_err  out  1  one-cycle pulse when select is released mid-word.

Behaviour:
- Reset (rst=0 at a clk edge) clears all state. Reset values: SPI_MISO=1, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, frame_err=0. The synchronizers reset to the bus idle level, SPI_CLK=1 and SPI_EN=1.
- Edge detection:
  - SPI_CLK and SPI_EN pass through SYNC_STAGES flops, then one extra edge-detect flop.
  - SPI_MOSI passes through the same number of stages, so it stays aligned with SPI_CLK.
  - An internal event fires SYNC_STAGES+1 clk cycles after the pin edge.
- TX holding register: tx_valid && tx_ready captures tx_data and drives tx_ready low the next cycle. tx_ready returns high the cycle after the holding register is moved into the shift register.
- FSM states: IDLE, LOAD, SHIFT.
  - IDLE: SPI_MISO=1. A synced SPI_EN falling edge goes to LOAD.
  - LOAD (1 cycle):
    - Shift register is loaded from the holding register if it is full.
    - Otherwise it is loaded with 0 and tx_underrun pulses.
    - Bit counter is cleared and the first_edge flag is set. Next state is SHIFT.
  - SHIFT:
    - SPI_MISO = tx_shift[MSB].
    - Synced SPI_CLK falling edge (leading edge): if first_edge, clear the flag only; otherwise shift tx_shift left by 1.
    - Synced SPI_CLK rising edge (trailing edge): shift the synced MOSI into rx_shift LSB first-in and increment the bit counter.
    - When the counter reaches DATA_WIDTH, rx_data <= assembled word the next cycle, rx_valid pulses for 1 cycle, and the FSM goes to LOAD. This allows back-to-back words under one select.
  - A synced SPI_EN rising edge in SHIFT or LOAD returns the FSM to IDLE.
    - frame_err pulses if the bit counter is between 1 and DATA_WIDTH-1.
    - A partial rx word is discarded.
    - Any unsent TX word is lost, not returned to the holding register.
  - An SPI_EN rise in the same cycle as the final rising edge: the completed word is delivered (rx_valid=1) with no frame_err, then the FSM goes to IDLE.
- SPI_CLK edges while SPI_EN is high are ignored.
- A tx_valid handshake in the same cycle as LOAD consumes the holding register: LOAD uses the old contents (or 0), and the new word is captured for the next word.
- Bit counter width is $clog2(DATA_WIDTH+1). No wrap occurs, because it is cleared in LOAD.

Optional Feature:
- Macro SPI_RESPONDER_MISO_OE_EN.
- When defined: adds output SPI_MISO_OE (1 bit). It is 1 only in LOAD and SHIFT, resets to 0, and board logic tristates SPI_MISO when it is 0.
- When undefined: no SPI_MISO_OE port; SPI_MISO is driven high in IDLE.

Decomposition:
- Package spi_pkg holds:
  - typedef spi_resp_state_t {IDLE, LOAD, SHIFT};
  - localparam SPI_CPOL=1, SPI_CPHA=1, SPI_WORD_BITS=8, shared with the master.
- One sub-module, spi_sync_edge: a parameterized SYNC_STAGES synchronizer with rise/fall pulse outputs. It is instantiated for SPI_CLK and SPI_EN. MOSI uses its synced-level output only.

Test Plan:
- Reset: hold rst=0 for 3 cycles with the bus toggling. Expect SPI_MISO=1, tx_ready=1, and no pulses on any flag.
- Single word, SPI_CLK = clk/8: preload tx_data=0xA5, master sends 0x3C. Expect MISO bits 1,0,1,0,0,1,0,1 at rising edges, then rx_data=0x3C with one rx_valid pulse; tx_ready is high again after LOAD.
- Back-to-back: two words under one select, TX 0x81 then 0x7E, master sends 0xF0 then 0x0F. Expect two rx_valid pulses carrying 0xF0 and 0x0F, and MISO carrying 0x81 then 0x7E.
- Underrun: select with no tx_valid. Expect tx_underrun pulse, MISO all zero, and rx still received correctly (0x55).
- Abort: release SPI_EN after 5 rising edges. Expect frame_err pulse, no rx_valid, return to IDLE with SPI_MISO=1, and the next full frame correct.
- Reset mid-frame: drive rst=0 after 3 bits. Expect reset values next cycle; a subsequent frame receiving 0xC3 works.
